// File: rtl/multiplexor_rr.sv
// N:1 registered valid/ready stream multiplexor with fixed-select and round-robin arbitration.
// Optional packet lock (in_last/out_last) is enabled by defining MULTIPLEXOR_RR_PKT_LOCK_EN.
module multiplexor_rr #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
   input  logic [N-1:0]    in_last,
   output logic            out_last,
`endif
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SELW-1:0] out_chan,
   output logic            sel_err
);

   logic [W-1:0]    chan_data [N];
   logic [W-1:0]    out_data_reg;
   logic            out_valid_reg;
   logic [SELW-1:0] out_chan_reg;
   logic            sel_err_reg;
   logic [SELW-1:0] last_reg;

   logic            load;
   logic            locked;
   logic            sel_ok;
   logic            fixed_hit;
   logic            rr_hit;
   logic [SELW-1:0] rr_grant;
   logic            lock_hit;
   logic            grant_hit;
   logic [SELW-1:0] grant;
   logic [W-1:0]    grant_data;
   logic            grant_last;
   logic            xfer;
   logic            sel_err_next;
   int              best_dist;

`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
   logic            lock_reg;
   logic [SELW-1:0] lock_chan_reg;
   logic            out_last_reg;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign chan_data[gi] = in_data[gi*W +: W];
      end
   endgenerate

   always_comb begin
      load       = !out_valid_reg || out_ready;
      sel_ok     = (int'(sel) < N);
      fixed_hit  = 1'b0;
      rr_hit     = 1'b0;
      rr_grant   = '0;
      lock_hit   = 1'b0;
      best_dist  = N;
      grant_data = '0;
      grant_last = 1'b0;
      in_ready   = '0;
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
      locked = lock_reg;
`else
      locked = 1'b0;
`endif

      // Round-robin: smallest distance above the last accepted channel wins.
      for (int i = 0; i < N; i++) begin
         if (in_valid[i] && ((i + 2*N - int'(last_reg) - 1) % N) < best_dist) begin
            best_dist = (i + 2*N - int'(last_reg) - 1) % N;
            rr_hit    = 1'b1;
            rr_grant  = SELW'(i);
         end
         if (int'(sel) == i && in_valid[i])
            fixed_hit = 1'b1;
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
         if (int'(lock_chan_reg) == i && in_valid[i])
            lock_hit = 1'b1;
`endif
      end

      if (locked) begin
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
         grant_hit = lock_hit;
         grant     = lock_chan_reg;
`else
         grant_hit = 1'b0;
         grant     = '0;
`endif
      end else if (mode) begin
         grant_hit = rr_hit;
         grant     = rr_grant;
      end else begin
         grant_hit = sel_ok && fixed_hit;
         grant     = sel;
      end

      // Gating with rst_n keeps every in_ready low while reset is held.
      xfer = load && grant_hit && rst_n;

      for (int i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            grant_data = chan_data[i];
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
            grant_last = in_last[i];
`endif
            if (xfer)
               in_ready[i] = 1'b1;
         end
      end

      sel_err_next = load && !mode && !sel_ok && !locked;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_chan_reg  <= '0;
         sel_err_reg   <= 1'b0;
         last_reg      <= SELW'(N-1);
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
         lock_reg      <= 1'b0;
         lock_chan_reg <= '0;
         out_last_reg  <= 1'b0;
`endif
      end else begin
         sel_err_reg <= sel_err_next;
         if (load)
            out_valid_reg <= xfer;
         if (xfer) begin
            out_data_reg <= grant_data;
            out_chan_reg <= grant;
            last_reg     <= grant;
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
            out_last_reg  <= grant_last;
            lock_reg      <= !grant_last;
            lock_chan_reg <= grant;
`endif
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_chan  = out_chan_reg;
   assign sel_err   = sel_err_reg;
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
   assign out_last  = out_last_reg;
`endif

   logic unused_grant_last;
   assign unused_grant_last = grant_last ^ lock_hit;

endmodule

// File: tb/tb_multiplexor_rr.sv
// Scoreboard bench for multiplexor_rr: N=4 instance for the main flows, N=3 instance for bad select.
module tb_multiplexor_rr;
   localparam int N    = 4;
   localparam int N3   = 3;
   localparam int W    = 8;
   localparam int SELW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic            mode;
   logic [SELW-1:0] sel;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [SELW-1:0] out_chan;
   logic            sel_err;

   logic [N3*W-1:0] in_data3;
   logic [N3-1:0]   in_valid3;
   logic [N3-1:0]   in_ready3;
   logic            mode3;
   logic [SELW-1:0] sel3;
   logic [W-1:0]    out_data3;
   logic            out_valid3;
   logic            out_ready3;
   logic [SELW-1:0] out_chan3;
   logic            sel_err3;

`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
   logic [N-1:0]    in_last;
   logic            out_last;
   logic [N3-1:0]   in_last3;
   logic            out_last3;
`endif

   int passed = 0;
   int total  = 0;
   logic [SELW+W-1:0] sb [$];
   logic [SELW+W-1:0] exp_e;

   always #5 clk = ~clk;

   multiplexor_rr #(.N(N), .W(W), .SELW(SELW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan),
      .sel_err   (sel_err)
   );

   multiplexor_rr #(.N(N3), .W(W), .SELW(SELW)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
      .in_last   (in_last3),
      .out_last  (out_last3),
`endif
      .mode      (mode3),
      .sel       (sel3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_chan  (out_chan3),
      .sel_err   (sel_err3)
   );

   task automatic set_ch(input int c, input logic [W-1:0] d);
      in_data[c*W +: W] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1; in_data = '0;
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_chan, sel_err, in_ready} !== '0)
         $display("FAIL reset_idle: got v=%b d=%h c=%0d e=%b rdy=%b required all zero",
                  out_valid, out_data, out_chan, sel_err, in_ready);
      else passed++;
      in_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mode = 1'b0; sel = 2'd1; set_ch(1, 8'h77); in_valid = 4'b0010; out_ready = 1'b0;
      sb.push_back({2'd1, 8'h77});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL reset_preload: scoreboard empty");
      else begin
         exp_e = sb.pop_front();
         if ({out_valid, out_chan, out_data} !== {1'b1, exp_e})
            $display("FAIL reset_preload: got v=%b c=%0d d=%h required v=1 c=%0d d=%h",
                     out_valid, out_chan, out_data, exp_e[W+:SELW], exp_e[W-1:0]);
         else passed++;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, out_data, out_chan, in_ready} !== '0)
         $display("FAIL reset_midstream: got v=%b d=%h c=%0d rdy=%b required all zero",
                  out_valid, out_data, out_chan, in_ready);
      else passed++;
      in_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int seq [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
      mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_ch(i, 8'(8'h40 + i));
      for (int k = 0; k < 9; k++) begin
         if (k == 6) in_valid = 4'b1010;
         @(negedge clk);
         total++;
         if (in_ready !== 4'(1 << seq[k]))
            $display("FAIL rr_ready%0d: got %b required %b", k, in_ready, 4'(1 << seq[k]));
         else passed++;
         sb.push_back({SELW'(seq[k]), 8'(8'h40 + seq[k])});
         @(posedge clk); #1;
         total++;
         if (sb.size() == 0) $display("FAIL rr_beat%0d: scoreboard empty", k);
         else begin
            exp_e = sb.pop_front();
            if ({out_valid, out_chan, out_data} !== {1'b1, exp_e})
               $display("FAIL rr_beat%0d: got v=%b c=%0d d=%h required v=1 c=%0d d=%h", k,
                        out_valid, out_chan, out_data, exp_e[W+:SELW], exp_e[W-1:0]);
            else passed++;
         end
      end
      in_valid = '0;
      @(posedge clk); #1;
      total++;
      if ({out_valid, out_chan, out_data} !== {1'b0, 2'd3, 8'h43})
         $display("FAIL rr_idle: got v=%b c=%0d d=%h required v=0 c=3 d=43",
                  out_valid, out_chan, out_data);
      else passed++;
   endtask

   task automatic test_fixed();
      mode = 1'b0; sel = 2'd2; set_ch(2, 8'hA5); in_valid = 4'b1111; out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 4'b0100) $display("FAIL fixed_ready: got %b required 0100", in_ready);
      else passed++;
      sb.push_back({2'd2, 8'hA5});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL fixed_beat: scoreboard empty");
      else begin
         exp_e = sb.pop_front();
         if ({out_valid, out_chan, out_data} !== {1'b1, exp_e})
            $display("FAIL fixed_beat: got v=%b c=%0d d=%h required v=1 c=%0d d=%h",
                     out_valid, out_chan, out_data, exp_e[W+:SELW], exp_e[W-1:0]);
         else passed++;
      end
      in_valid = '0;
      @(posedge clk); #1;
      total++;
      if ({out_valid, out_chan, out_data} !== {1'b0, 2'd2, 8'hA5})
         $display("FAIL fixed_hold_idle: got v=%b c=%0d d=%h required v=0 c=2 d=a5",
                  out_valid, out_chan, out_data);
      else passed++;
   endtask

   task automatic test_backpressure();
      mode = 1'b0; sel = 2'd3; set_ch(3, 8'h3C); in_valid = 4'b1111; out_ready = 1'b0;
      sb.push_back({2'd3, 8'h3C});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL bp_load: scoreboard empty");
      else begin
         exp_e = sb.pop_front();
         if ({out_valid, out_chan, out_data} !== {1'b1, exp_e})
            $display("FAIL bp_load: got v=%b c=%0d d=%h required v=1 c=%0d d=%h",
                     out_valid, out_chan, out_data, exp_e[W+:SELW], exp_e[W-1:0]);
         else passed++;
      end
      set_ch(3, 8'hC3); set_ch(1, 8'h5A);
      for (int h = 0; h < 3; h++) begin
         if (h == 1) sel = 2'd1;
         @(negedge clk);
         total++;
         if ({in_ready, out_valid, out_chan, out_data} !== {4'b0000, 1'b1, 2'd3, 8'h3C})
            $display("FAIL bp_hold%0d: got rdy=%b v=%b c=%0d d=%h required rdy=0000 v=1 c=3 d=3c",
                     h, in_ready, out_valid, out_chan, out_data);
         else passed++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b required 0010", in_ready);
      else passed++;
      sb.push_back({2'd1, 8'h5A});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL bp_next: scoreboard empty");
      else begin
         exp_e = sb.pop_front();
         if ({out_valid, out_chan, out_data} !== {1'b1, exp_e})
            $display("FAIL bp_next: got v=%b c=%0d d=%h required v=1 c=%0d d=%h",
                     out_valid, out_chan, out_data, exp_e[W+:SELW], exp_e[W-1:0]);
         else passed++;
      end
      in_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_bad_sel();
      mode3 = 1'b0; sel3 = 2'd0; in_data3 = {8'h33, 8'h22, 8'h11}; in_valid3 = 3'b111; out_ready3 = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready3 !== 3'b001) $display("FAIL bad_pre_ready: got %b required 001", in_ready3);
      else passed++;
      sb.push_back({2'd0, 8'h11});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL bad_pre_beat: scoreboard empty");
      else begin
         exp_e = sb.pop_front();
         if ({out_valid3, out_chan3, out_data3} !== {1'b1, exp_e})
            $display("FAIL bad_pre_beat: got v=%b c=%0d d=%h required v=1 c=%0d d=%h",
                     out_valid3, out_chan3, out_data3, exp_e[W+:SELW], exp_e[W-1:0]);
         else passed++;
      end
      sel3 = 2'd3;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         total++;
         if (in_ready3 !== 3'b000) $display("FAIL bad_ready%0d: got %b required 000", b, in_ready3);
         else passed++;
         @(posedge clk); #1;
         total++;
         if ({sel_err3, out_valid3} !== 2'b10)
            $display("FAIL bad_err%0d: got sel_err=%b v=%b required sel_err=1 v=0", b, sel_err3, out_valid3);
         else passed++;
      end
      sel3 = 2'd1;
      sb.push_back({2'd1, 8'h22});
      @(posedge clk); #1;
      total++;
      if (sb.size() == 0) $display("FAIL bad_resume: scoreboard empty");
      else begin
         exp_e = sb.pop_front();
         if ({sel_err3, out_valid3, out_chan3, out_data3} !== {2'b01, exp_e})
            $display("FAIL bad_resume: got e=%b v=%b c=%0d d=%h required e=0 v=1 c=%0d d=%h",
                     sel_err3, out_valid3, out_chan3, out_data3, exp_e[W+:SELW], exp_e[W-1:0]);
         else passed++;
      end
      sel3 = 2'd3; out_ready3 = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({sel_err3, out_valid3, out_data3} !== {2'b01, 8'h22})
         $display("FAIL bad_busy: got e=%b v=%b d=%h required e=0 v=1 d=22", sel_err3, out_valid3, out_data3);
      else passed++;
      in_valid3 = '0; sel3 = 2'd0; out_ready3 = 1'b1;
      @(posedge clk); #1;
   endtask

`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
   task automatic test_pkt_lock();
      int  chans [4] = '{0, 0, 0, 1};
      int  datas [4] = '{8'hD0, 8'hD1, 8'hD2, 8'hE1};
      logic lasts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0011; in_last = '0; set_ch(1, 8'hE1);
      for (int b = 0; b < 4; b++) begin
         if (b < 3) begin
            set_ch(0, 8'(8'hD0 + b));
            in_last[0] = (b == 2);
         end
         sb.push_back({SELW'(chans[b]), 8'(datas[b])});
         @(posedge clk); #1;
         total++;
         if (sb.size() == 0) $display("FAIL lock_beat%0d: scoreboard empty", b);
         else begin
            exp_e = sb.pop_front();
            if ({out_valid, out_chan, out_data, out_last} !== {1'b1, exp_e, lasts[b]})
               $display("FAIL lock_beat%0d: got v=%b c=%0d d=%h l=%b required v=1 c=%0d d=%h l=%b", b,
                        out_valid, out_chan, out_data, out_last, exp_e[W+:SELW], exp_e[W-1:0], lasts[b]);
            else passed++;
         end
      end
      in_valid = '0;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
      in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
      in_last = '0; in_last3 = '0;
`endif
      test_reset();
      test_round_robin();
      test_fixed();
      test_backpressure();
      test_bad_sel();
`ifdef MULTIPLEXOR_RR_PKT_LOCK_EN
      test_pkt_lock();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
